// File: rtl/gestor_ocupacion.sv
// Occupancy manager: edge-detected entry/exit events drive a saturating car count,
// and impossible events raise a timed, blinking alert.
module gestor_ocupacion #(
    parameter int CAPACIDAD  = 7,
    parameter int ANCHO      = 3,
    parameter int T_ALERTA   = 12000000,
    parameter int T_PARPADEO = 3000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    output logic [ANCHO-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio,
    output logic             alerta,
    output logic             led_alerta,
    output logic [1:0]       error_tipo
);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] ALERTA = 1'b1;

    localparam int TA_W = (T_ALERTA   > 1) ? $clog2(T_ALERTA)   : 1;
    localparam int TP_W = (T_PARPADEO > 1) ? $clog2(T_PARPADEO) : 1;

    localparam logic [ANCHO-1:0] CAP    = ANCHO'(CAPACIDAD);
    localparam logic [TA_W-1:0]  TA_FIN = TA_W'(T_ALERTA - 1);
    localparam logic [TP_W-1:0]  TP_FIN = TP_W'(T_PARPADEO - 1);

    logic             s_prev_q, r_prev_q;
    logic [ANCHO-1:0] ocup_q, ocup_d;
    logic [0:0]       estado_q, estado_d;
    logic [TA_W-1:0]  t_alerta_q, t_alerta_d;
    logic [TP_W-1:0]  t_parp_q, t_parp_d;
    logic             led_q, led_d;
    logic [1:0]       err_q, err_d;
    logic             ev_s, ev_r, rechazo;

    always_comb begin
        ev_s    = s & ~s_prev_q;
        ev_r    = r & ~r_prev_q;
        ocup_d  = ocup_q;
        err_d   = err_q;
        rechazo = 1'b0;

        // Simultaneous entry and exit cancel out and never raise an alert.
        if (ev_s && !ev_r) begin
            if (ocup_q < CAP) begin
                ocup_d = ocup_q + ANCHO'(1);
            end else begin
                rechazo = 1'b1;
                err_d   = 2'b01;
            end
        end else if (ev_r && !ev_s) begin
            if (ocup_q != '0) begin
                ocup_d = ocup_q - ANCHO'(1);
            end else begin
                rechazo = 1'b1;
                err_d   = 2'b10;
            end
        end

        estado_d   = estado_q;
        t_alerta_d = t_alerta_q;
        t_parp_d   = t_parp_q;
        led_d      = led_q;

        if (rechazo) begin
            estado_d   = ALERTA;
            t_alerta_d = '0;
            t_parp_d   = '0;
            led_d      = 1'b1;
        end else if (estado_q == ALERTA) begin
            if (t_alerta_q == TA_FIN) begin
                estado_d   = NORMAL;
                t_alerta_d = '0;
                t_parp_d   = '0;
                led_d      = 1'b0;
            end else begin
                t_alerta_d = t_alerta_q + TA_W'(1);
                if (t_parp_q == TP_FIN) begin
                    t_parp_d = '0;
                    led_d    = ~led_q;
                end else begin
                    t_parp_d = t_parp_q + TP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q   <= 1'b0;
            r_prev_q   <= 1'b0;
            ocup_q     <= '0;
            estado_q   <= NORMAL;
            t_alerta_q <= '0;
            t_parp_q   <= '0;
            led_q      <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            s_prev_q   <= s;
            r_prev_q   <= r;
            ocup_q     <= ocup_d;
            estado_q   <= estado_d;
            t_alerta_q <= t_alerta_d;
            t_parp_q   <= t_parp_d;
            led_q      <= led_d;
            err_q      <= err_d;
        end
    end

    assign ocupacion  = ocup_q;
    assign lleno      = (ocup_q == CAP);
    assign vacio      = (ocup_q == '0);
    assign alerta     = (estado_q == ALERTA);
    assign led_alerta = led_q;
    assign error_tipo = err_q;

endmodule

// File: tb/tb_gestor_ocupacion.sv
// Scoreboard bench for gestor_ocupacion: a behavioural model queues the expected
// output word for each cycle, and the word is compared just after the clock edge.
module tb_gestor_ocupacion;

    localparam int CAP = 3;
    localparam int AN  = 3;
    localparam int TA  = 20;
    localparam int TP  = 5;

    // Output word layout: {ocupacion[2:0], lleno, vacio, alerta, led_alerta, error_tipo[1:0]}
    localparam logic [15:0] RESET_VEC = 16'b0000000_000_0_1_0_0_00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s   = 1'b0;
    logic          r   = 1'b0;
    logic [AN-1:0] ocupacion;
    logic          lleno, vacio, alerta, led_alerta;
    logic [1:0]    error_tipo;

    gestor_ocupacion #(
        .CAPACIDAD (CAP),
        .ANCHO     (AN),
        .T_ALERTA  (TA),
        .T_PARPADEO(TP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s),
        .r         (r),
        .ocupacion (ocupacion),
        .lleno     (lleno),
        .vacio     (vacio),
        .alerta    (alerta),
        .led_alerta(led_alerta),
        .error_tipo(error_tipo)
    );

    always #5 clk = ~clk;

    int vec_count  = 0;
    int miscompare = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_vec;
    int          alert_cycles;

    int m_ocup, m_left, m_elapsed, m_err;
    bit m_ps, m_pr;

    function automatic logic [15:0] dut_word();
        return {7'b0, ocupacion, lleno, vacio, alerta, led_alerta, error_tipo};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vec_count++;
        if (obs !== expv) begin
            miscompare++;
            $display("FAIL %s: observed %h required %h", tag, obs, expv);
        end else begin
            $display("vec %0d %s ok %h", vec_count, tag, obs);
        end
    endtask

    task automatic model_reset();
        m_ocup = 0; m_left = 0; m_elapsed = 0; m_err = 0; m_ps = 0; m_pr = 0;
    endtask

    // Behavioural model: alert tracked as cycles remaining, blink phase from elapsed time.
    task automatic model_step(input bit sv, input bit rv);
        bit ev_s, ev_r, rej;
        logic [15:0] w;
        ev_s = sv && !m_ps;
        ev_r = rv && !m_pr;
        m_ps = sv;
        m_pr = rv;
        rej  = 0;
        if (ev_s && !ev_r) begin
            if (m_ocup < CAP) m_ocup++;
            else begin rej = 1; m_err = 1; end
        end else if (ev_r && !ev_s) begin
            if (m_ocup > 0) m_ocup--;
            else begin rej = 1; m_err = 2; end
        end
        if (rej) begin
            m_left = TA;
            m_elapsed = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_elapsed++;
        end
        w = '0;
        w[8:6] = 3'(m_ocup);
        w[5]   = (m_ocup == CAP);
        w[4]   = (m_ocup == 0);
        w[3]   = (m_left > 0);
        w[2]   = (m_left > 0) && (((m_elapsed / TP) % 2) == 0);
        w[1:0] = 2'(m_err);
        exp_q.push_back(w);
    endtask

    task automatic step(input bit sv, input bit rv, input string tag);
        logic [15:0] e;
        s = sv;
        r = rv;
        model_step(sv, rv);
        @(posedge clk);
        #1;
        obs_vec = dut_word();
        if (obs_vec[3]) alert_cycles++;
        if (exp_q.size() == 0) begin
            vec_count++;
            miscompare++;
            $display("FAIL %s: observed %h required queued entry", tag, obs_vec);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, obs_vec, e);
        end
    endtask

    task automatic pulse(input bit sv, input bit rv, input int gap, input string tag);
        step(sv, rv, tag);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_val("reset", dut_word(), RESET_VEC);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill the lot with three spaced entries
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, "fill");
            check_val("fill_ocup", {13'b0, obs_vec[8:6]}, 16'(k));
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "fill");
        end
        check_val("lleno", {15'b0, obs_vec[5]}, 16'd1);

        // Entry while full: rejected, 20-cycle alert
        alert_cycles = 0;
        step(1'b1, 1'b0, "full_rej");
        check_val("err_full", {14'b0, obs_vec[1:0]}, 16'd1);
        check_val("ocup_full", {13'b0, obs_vec[8:6]}, 16'd3);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, "alert_full");
        check_val("alert_len1", 16'(alert_cycles), 16'd20);

        // Empty the lot, then two rejected exits 10 cycles apart
        for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 3, "drain");
        step(1'b0, 1'b1, "empty_rej");
        check_val("err_empty", {14'b0, obs_vec[1:0]}, 16'd2);
        check_val("vacio_rej", {15'b0, obs_vec[4]}, 16'd1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, "alert_empty");
        alert_cycles = 0;
        step(1'b0, 1'b1, "empty_rej2");
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, "alert_ext");
        check_val("alert_len2", 16'(alert_cycles), 16'd20);

        // Held entry counts once
        pulse(1'b1, 1'b0, 3, "to_one");
        alert_cycles = 0;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, "s_held");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "s_held");
        check_val("held_ocup", {13'b0, obs_vec[8:6]}, 16'd2);
        check_val("held_noalert", 16'(alert_cycles), 16'd0);

        // Simultaneous events at full and at empty
        pulse(1'b1, 1'b0, 3, "to_full");
        alert_cycles = 0;
        pulse(1'b1, 1'b1, 3, "both_full");
        check_val("both_full_ocup", {13'b0, obs_vec[8:6]}, 16'd3);
        for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 3, "drain2");
        pulse(1'b1, 1'b1, 3, "both_empty");
        check_val("both_empty_ocup", {13'b0, obs_vec[8:6]}, 16'd0);
        check_val("both_noalert", 16'(alert_cycles), 16'd0);

        // Asynchronous reset in the middle of an alert at ocupacion=2
        for (int k = 0; k < 3; k++) pulse(1'b1, 1'b0, 2, "refill");
        step(1'b1, 1'b0, "rej_again");
        pulse(1'b0, 1'b1, 3, "exit_in_alert");
        check_val("pre_rst", {12'b0, obs_vec[8:6], obs_vec[3]}, 16'b0101);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_rst", dut_word(), RESET_VEC);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, "post_rst");
        check_val("post_rst_ocup", {13'b0, obs_vec[8:6]}, 16'd1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
